// File: rtl/stage_pkg.sv
// Shared constants for the jump-game platform queue: colour codes,
// the two start-of-game platforms and the queue controller states.
package stage_pkg;

  localparam logic [1:0] COLOR_BLACK = 2'd0;
  localparam logic [1:0] COLOR_BLUE  = 2'd1;
  localparam logic [1:0] COLOR_GREEN = 2'd2;
  localparam logic [1:0] COLOR_RED   = 2'd3;

  localparam int INIT0_X = 60;
  localparam int INIT0_W = 60;
  localparam int INIT1_X = 200;
  localparam int INIT1_W = 60;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCROLL,
    ST_FILL
  } stage_state_t;

endpackage

// File: rtl/stage_queue_if.sv
// Platform-creator handshake: the queue raises gen_req, the creator answers
// with gen_ack and a new platform in the same cycle.
interface stage_queue_if #(
  parameter int XW = 10,
  parameter int CW = 2
);
  logic          gen_req;
  logic          gen_ack;
  logic [XW-1:0] new_x;
  logic [XW-1:0] new_w;
  logic [CW-1:0] new_color;

  modport master (output gen_req, input gen_ack, new_x, new_w, new_color);
  modport slave  (input gen_req, output gen_ack, new_x, new_w, new_color);
endinterface

// File: rtl/stage_clamp.sv
// Combinational placement clamp for an appended platform: keeps MIN_GAP
// behind the current tail and trims the width at the right screen bound.
module stage_clamp
  import stage_pkg::*;
#(
  parameter int XW      = 10,
  parameter int X_MAX   = 400,
  parameter int MIN_GAP = 10
) (
  input  logic [XW-1:0] new_x,
  input  logic [XW-1:0] new_w,
  input  logic [XW:0]   tail_end,
  output logic [XW-1:0] x,
  output logic [XW-1:0] w,
  output logic          ok
);
  localparam int EW = XW + 2;

  logic [EW-1:0] floor_x;
  logic [EW-1:0] cand_x;
  logic [EW-1:0] room;
  logic [EW-1:0] cand_w;

  assign floor_x = {1'b0, tail_end} + EW'(MIN_GAP);
  assign cand_x  = ({2'b00, new_x} > floor_x) ? {2'b00, new_x} : floor_x;
  assign room    = (cand_x < EW'(X_MAX)) ? EW'(X_MAX) - cand_x : '0;
  assign cand_w  = ({2'b00, new_w} < room) ? {2'b00, new_w} : room;

  assign x  = cand_x[XW-1:0];
  assign w  = cand_w[XW-1:0];
  // An x beyond the stored width can only occur with zero room, but reject it explicitly.
  assign ok = (cand_w != '0) && (cand_x[EW-1:XW] == '0);
endmodule

// File: rtl/stage_queue.sv
// Platform queue for the jump game: scrolls, retires and refills up to
// N_STAGES platforms. Define CLAMP_EN to clamp appended platforms on screen.
module stage_queue
  import stage_pkg::*;
#(
  parameter int  N_STAGES    = 4,
  parameter int  XW          = 10,
  parameter int  CW          = 2,
  parameter int  X_MAX       = 400,
  parameter int  SCROLL_STEP = 4,
  parameter int  MIN_GAP     = 10,
  localparam int CNTW        = $clog2(N_STAGES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         init_en,
  input  logic                         advance_en,
  input  logic                         scroll_req,
  input  logic [XW-1:0]                scroll_dx,
  stage_queue_if.master                gen,
  output logic [XW:0]                  tail_end,
  output logic [N_STAGES-1:0][XW-1:0]  stage_x,
  output logic [N_STAGES-1:0][XW-1:0]  stage_w,
  output logic [N_STAGES-1:0][CW-1:0]  stage_color,
  output logic [CNTW-1:0]              count,
  output logic                         busy,
  output logic                         scroll_done
);
  localparam logic [CNTW-1:0] FULL     = CNTW'(N_STAGES);
  localparam logic [XW-1:0]   STEP_MAX = XW'(SCROLL_STEP);

  if (N_STAGES < 2 || X_MAX <= MIN_GAP || SCROLL_STEP < 1) begin : g_bad_params
    $error("stage_queue: unsupported parameter set");
  end

  stage_state_t                state_reg;
  logic [N_STAGES-1:0][XW-1:0] x_reg;
  logic [N_STAGES-1:0][XW-1:0] w_reg;
  logic [N_STAGES-1:0][CW-1:0] c_reg;
  logic [CNTW-1:0]             count_reg;
  logic [XW-1:0]               rem_reg;
  logic                        gen_req_reg;
  logic                        scroll_done_reg;

  logic [XW-1:0]               step;
  logic [XW-1:0]               rem_next;
  logic [N_STAGES-1:0][XW-1:0] scr_x, scr_w;
  logic [N_STAGES-1:0][XW-1:0] rsh_x, rsh_w;
  logic [N_STAGES-1:0][XW-1:0] pop_x, pop_w;
  logic [N_STAGES-1:0][CW-1:0] pop_c;
  logic [XW:0]                 head_end;
  logic                        retire;
  logic [CNTW-1:0]             count_dec, count_inc, scroll_cnt;
  logic [XW-1:0]               app_x, app_w;
  logic                        app_ok;

  assign step      = (rem_reg < STEP_MAX) ? rem_reg : STEP_MAX;
  assign rem_next  = rem_reg - step;
  assign head_end  = {1'b0, x_reg[0]} + {1'b0, w_reg[0]};
  // Retire is judged on the pre-scroll head: it leaves once its right edge is within this step.
  assign retire    = (count_reg != '0) && (head_end <= {1'b0, step});
  assign count_dec = (count_reg != '0) ? count_reg - CNTW'(1) : '0;
  assign count_inc = count_reg + CNTW'(1);
  assign scroll_cnt = retire ? count_dec : count_reg;

  for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_entry
    logic          valid;
    logic          behind;
    logic [XW-1:0] overrun;

    assign valid   = CNTW'(gi) < count_reg;
    assign behind  = x_reg[gi] < step;
    assign overrun = step - x_reg[gi];

    assign scr_x[gi] = !valid ? x_reg[gi] : (behind ? '0 : x_reg[gi] - step);
    assign scr_w[gi] = (valid && behind)
                     ? ((w_reg[gi] > overrun) ? w_reg[gi] - overrun : '0)
                     : w_reg[gi];

    if (gi < N_STAGES - 1) begin : g_shift
      assign pop_x[gi] = x_reg[gi+1];
      assign pop_w[gi] = w_reg[gi+1];
      assign pop_c[gi] = c_reg[gi+1];
      assign rsh_x[gi] = scr_x[gi+1];
      assign rsh_w[gi] = scr_w[gi+1];
    end else begin : g_tail
      assign pop_x[gi] = '0;
      assign pop_w[gi] = '0;
      assign pop_c[gi] = '0;
      assign rsh_x[gi] = '0;
      assign rsh_w[gi] = '0;
    end
  end

  always_comb begin
    tail_end = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      if (count_reg == CNTW'(i + 1)) begin
        tail_end = {1'b0, x_reg[i]} + {1'b0, w_reg[i]};
      end
    end
  end

`ifdef CLAMP_EN
  stage_clamp #(
    .XW      (XW),
    .X_MAX   (X_MAX),
    .MIN_GAP (MIN_GAP)
  ) u_clamp (
    .new_x    (gen.new_x),
    .new_w    (gen.new_w),
    .tail_end (tail_end),
    .x        (app_x),
    .w        (app_w),
    .ok       (app_ok)
  );
`else
  assign app_x  = gen.new_x;
  assign app_w  = gen.new_w;
  assign app_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      x_reg           <= '0;
      w_reg           <= '0;
      c_reg           <= '0;
      count_reg       <= '0;
      rem_reg         <= '0;
      gen_req_reg     <= 1'b0;
      scroll_done_reg <= 1'b0;
    end else begin
      scroll_done_reg <= 1'b0;
      if (init_en) begin
        x_reg     <= '0;
        w_reg     <= '0;
        c_reg     <= '0;
        x_reg[0]  <= XW'(INIT0_X);
        w_reg[0]  <= XW'(INIT0_W);
        c_reg[0]  <= CW'(COLOR_BLUE);
        x_reg[1]  <= XW'(INIT1_X);
        w_reg[1]  <= XW'(INIT1_W);
        c_reg[1]  <= CW'(COLOR_BLACK);
        count_reg <= CNTW'(2);
        rem_reg   <= '0;
        if (N_STAGES > 2) begin
          state_reg   <= ST_FILL;
          gen_req_reg <= 1'b1;
        end else begin
          state_reg   <= ST_IDLE;
          gen_req_reg <= 1'b0;
        end
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (advance_en) begin
              x_reg       <= pop_x;
              w_reg       <= pop_w;
              c_reg       <= pop_c;
              count_reg   <= count_dec;
              state_reg   <= ST_FILL;
              gen_req_reg <= 1'b1;
            end else if (scroll_req) begin
              rem_reg   <= scroll_dx;
              state_reg <= ST_SCROLL;
            end
          end
          ST_SCROLL: begin
            rem_reg <= rem_next;
            if (retire) begin
              x_reg     <= rsh_x;
              w_reg     <= rsh_w;
              c_reg     <= pop_c;
              count_reg <= count_dec;
            end else begin
              x_reg <= scr_x;
              w_reg <= scr_w;
            end
            if (rem_next == '0) begin
              scroll_done_reg <= 1'b1;
              if (scroll_cnt < FULL) begin
                state_reg   <= ST_FILL;
                gen_req_reg <= 1'b1;
              end else begin
                state_reg <= ST_IDLE;
              end
            end
          end
          ST_FILL: begin
            if (count_reg >= FULL) begin
              state_reg   <= ST_IDLE;
              gen_req_reg <= 1'b0;
            end else if (gen.gen_ack && app_ok) begin
              for (int i = 0; i < N_STAGES; i++) begin
                if (count_reg == CNTW'(i)) begin
                  x_reg[i] <= app_x;
                  w_reg[i] <= app_w;
                  c_reg[i] <= gen.new_color;
                end
              end
              count_reg <= count_inc;
              if (count_inc == FULL) begin
                state_reg   <= ST_IDLE;
                gen_req_reg <= 1'b0;
              end
            end
          end
          default: begin
            state_reg   <= ST_IDLE;
            gen_req_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign gen.gen_req = gen_req_reg;
  assign stage_x     = x_reg;
  assign stage_w     = w_reg;
  assign stage_color = c_reg;
  assign count       = count_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign scroll_done = scroll_done_reg;
endmodule

// File: doc/stage_queue.md
Name: stage_queue

Overview:
Parametrised platform queue for the jump game; successor to the two-entry stage register. Holds up to N_STAGES platforms (x, w, colour) in left-to-right order. Animates horizontal scrolling over several cycles, retires platforms that leave the screen and refills the tail from the platform creator over a req/ack handshake. Sits between the game-control FSM and the renderer/collision logic.

Parameters:
N_STAGES, 4, queue depth (>=2)
XW, 10, x/width bit width
CW, 2, colour bit width
X_MAX, 400, right screen bound for x+w
SCROLL_STEP, 4, max pixels scrolled per cycle
MIN_GAP, 10, minimum gap enforced by CLAMP_EN

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
init_en  in  1  load initial two platforms (pulse)
advance_en  in  1  pop head platform (pulse)
scroll_req  in  1  start scroll (pulse)
scroll_dx  in  XW  total scroll distance, sampled with scroll_req
gen_req  out  1  request new platform from creator
gen_ack  in  1  new_* valid this cycle
new_x, new_w  in  XW  creator platform
new_color  in  CW  creator colour
tail_end  out  XW+1  x+w of tail (0 if empty), creator minimum
stage_x, stage_w  out  XW x N_STAGES  platform arrays, index 0 = head
stage_color  out  CW x N_STAGES
count  out  $clog2(N_STAGES+1)  valid entries
busy  out  1  state != IDLE
scroll_done  out  1  one-cycle pulse at end of scroll

Behaviour:
- Reset (rst=0, async): all arrays 0, count 0, state IDLE, gen_req 0, scroll_done 0.
- States: IDLE, SCROLL, FILL.
- init_en: highest priority, any state. Next edge: entry0 = (60,60,BLUE), entry1 = (200,60,0), others 0, count 2, remaining scroll cleared. Then FILL if N_STAGES>2, else IDLE.
- IDLE: requests accepted only here. advance_en beats scroll_req; a losing or non-IDLE request is dropped.
- advance_en: shift entries down by one, zero the tail slot, count-1 (no change if 0), go to FILL.
- scroll_req: latch rem=scroll_dx. Go to SCROLL; dx=0 goes straight through with scroll_done next cycle.
- SCROLL, per cycle: step = min(SCROLL_STEP, rem); rem -= step.
  - For each valid entry: if x>=step then x-=step, else w -= (step-x) and x=0.
  - If head x+w <= step, retire head: shift down, count-1. At most one retirement per cycle.
  - When rem reaches 0: pulse scroll_done on that cycle's edge. Next state FILL if count<N_STAGES, else IDLE.
- FILL: gen_req=1 while count<N_STAGES.
  - On gen_ack: write new_* at index count, count+1.
  - count==N_STAGES: gen_req drops the same edge, go to IDLE.
  - gen_ack outside FILL is ignored.
- Width rules: tail_end computed in XW+1 bits, no wrap. Scroll subtraction never underflows (saturates as above).
- Entries at index >= count read 0.

Optional Feature:
CLAMP_EN.
- Defined: an appended platform is forced to stored x = max(new_x, tail_end+MIN_GAP). Then w = min(new_w, X_MAX - x). If that leaves w=0, the append is dropped and gen_req stays high.
- Undefined: new_* stored verbatim.

Decomposition:
- Package stage_pkg: colour constants (BLUE etc., shared with the existing parameter defines), initial platform constants (60/60, 200/60), state enum.
- One sub-module is natural: stage_clamp, combinational x/w clamp, instantiated only under CLAMP_EN.

Test Plan:
1. Reset: rst=0 mid-FILL -> all outputs 0, count 0, busy 0 immediately.
2. Init then fill (N=4): init_en -> entry0=(60,60,BLUE), entry1=(200,60,0), count 2, gen_req=1, tail_end=260. Ack (300,40) then (360,30) -> count 4, gen_req=0, busy=0.
3. Short scroll: scroll_dx=10 -> 3 cycles (steps 4,4,2), entry0 x 60->50, entry1 200->190, scroll_done on cycle 3, back to IDLE.
4. Retire: from the state after test 2, scroll_dx=120.
   - Head x hits 0 after 15 cycles, w shrinks to 0 at cycle 30 and the head retires.
   - New head x=80, count 3, FILL with gen_req=1.
5. Priority: advance_en and scroll_req in the same IDLE cycle -> head popped, count-1, scroll ignored. init_en during SCROLL -> init values loaded, scroll aborted, no scroll_done.
6. CLAMP_EN, tail_end=300, MIN_GAP=10:
   - Ack (250,40) -> stored (310,40).
   - Ack (395,20) -> stored (395,5).
   - Without macro: stored (250,40).
